// File: rtl/countdown_pkg.sv
// countdown_pkg: shared types for the countdown timer.
//   state_t : IDLE (stopped/paused), RUN (counting), DONE (expired, waiting for load/reset)
package countdown_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/countdown_timer_if.sv
// countdown_timer_if: control/status bundle of the countdown timer.
//   load, load_value, start, stop : driven by master into the timer
//   count, running, expired       : driven by the timer (slave) back to master
interface countdown_timer_if #(parameter int DATA_WIDTH = 16);
    logic                  load;
    logic [DATA_WIDTH-1:0] load_value;
    logic                  start;
    logic                  stop;
    logic [DATA_WIDTH-1:0] count;
    logic                  running;
    logic                  expired;
    modport master (output load, load_value, start, stop, input count, running, expired);
    modport slave  (input load, load_value, start, stop, output count, running, expired);
endinterface

// File: rtl/countdown_timer_tick_gen.sv
// tick_gen: prescaler, one tick every PRESCALE enabled cycles.
//   clk, reset : clock, synchronous active-high reset
//   clr        : force prescaler to 0
//   en         : counting cycle; prescaler advances only when high
//   tick       : en and prescaler at PRESCALE-1 (equals en when PRESCALE=1)
module tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);
    // Width clamped to 1 so PRESCALE=1 still builds; the counter then stays at 0.
    localparam int W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    logic [W-1:0] pre;
    assign tick = en && (pre == W'(PRESCALE - 1));
    always_ff @(posedge clk) begin
        if (reset || clr) pre <= '0;
        else if (en)      pre <= tick ? '0 : pre + 1'b1;
    end
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with prescaler, pause and expiry pulse.
//   clk, reset : clock, synchronous active-high reset
//   bus        : countdown_timer_if.slave (load/load_value/start/stop in; count/running/expired out)
//   Optional macro COUNTDOWN_AUTO_RELOAD_EN: on expiry reload the last loaded value and keep running.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int PRESCALE   = 1
) (
    input logic              clk,
    input logic              reset,
    countdown_timer_if.slave bus
);
    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] count_q, count_n;
    logic                  expired_q, expired_n;
    logic                  en, tick, fire;
    // A counting cycle: RUN without stop, or the start cycle out of IDLE with a nonzero count.
    assign en   = !bus.load && !bus.stop &&
                  (state == RUN || (state == IDLE && bus.start && count_q != '0));
    assign fire = tick && count_q == DATA_WIDTH'(1);
    tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clk  (clk),
        .reset(reset),
        .clr  (bus.load || fire),
        .en   (en),
        .tick (tick)
    );
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [DATA_WIDTH-1:0] reload_q;
    always_ff @(posedge clk) begin
        if (reset)         reload_q <= '0;
        else if (bus.load) reload_q <= bus.load_value;
    end
`endif
    always_comb begin
        state_n   = state;
        count_n   = count_q;
        expired_n = 1'b0;
        if (bus.load) begin
            state_n = IDLE;
            count_n = bus.load_value;
        end else if (en) begin
            state_n = RUN;
            if (fire) begin
                expired_n = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                count_n = reload_q;
                state_n = reload_q == '0 ? DONE : RUN;
`else
                count_n = '0;
                state_n = DONE;
`endif
            end else if (tick) begin
                count_n = count_q - 1'b1;
            end
        end else if (state == RUN && bus.stop) begin
            state_n = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            state     <= state_n;
            count_q   <= count_n;
            expired_q <= expired_n;
        end
    end
    assign bus.count   = count_q;
    assign bus.running = state == RUN;
    assign bus.expired = expired_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: table-driven scoreboard bench for countdown_timer at PRESCALE 1 and 3.
module tb_countdown_timer;
    typedef struct {
        logic        rst, load;
        logic [15:0] lv;
        logic        start, stop;
        logic [15:0] ecount;
        logic        erun, eexp;
    } vec_t;
    typedef struct {
        bit   d;
        int   n;
        vec_t v;
    } sb_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    countdown_timer_if #(.DATA_WIDTH(16)) if1 ();
    countdown_timer_if #(.DATA_WIDTH(16)) if3 ();
    countdown_timer #(.DATA_WIDTH(16), .PRESCALE(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    countdown_timer #(.DATA_WIDTH(16), .PRESCALE(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));

    int   compared = 0;
    int   mismatched = 0;
    sb_t  sb[$];
    vec_t t1[$];
    vec_t t3[$];

    function automatic vec_t mk(logic rst, logic load, logic [15:0] lv, logic start, logic stop,
                                logic [15:0] ec, logic er, logic ee);
        vec_t v;
        v.rst = rst; v.load = load; v.lv = lv; v.start = start; v.stop = stop;
        v.ecount = ec; v.erun = er; v.eexp = ee;
        return v;
    endfunction

    task automatic chk(input int n, input bit d, input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL p%0d step %0d %s: got %0d expected %0d", d ? 3 : 1, n, name, act, exp);
        end
    endtask

    task automatic step(input bit d, input int n, input vec_t v);
        sb_t e;
        @(negedge clk);
        reset = v.rst;
        if1.load = d ? 1'b0 : v.load;  if1.load_value = d ? 16'd0 : v.lv;
        if1.start = d ? 1'b0 : v.start; if1.stop = d ? 1'b0 : v.stop;
        if3.load = d ? v.load : 1'b0;  if3.load_value = d ? v.lv : 16'd0;
        if3.start = d ? v.start : 1'b0; if3.stop = d ? v.stop : 1'b0;
        e.d = d; e.n = n; e.v = v;
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        sb_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.n, e.d, "count",   e.d ? if3.count : if1.count, e.v.ecount);
            chk(e.n, e.d, "running", {15'd0, e.d ? if3.running : if1.running}, {15'd0, e.v.erun});
            chk(e.n, e.d, "expired", {15'd0, e.d ? if3.expired : if1.expired}, {15'd0, e.v.eexp});
        end
    end

    initial begin
        if1.load = 0; if1.load_value = 0; if1.start = 0; if1.stop = 0;
        if3.load = 0; if3.load_value = 0; if3.start = 0; if3.stop = 0;
        // PRESCALE=1: reset, load 5, single-cycle start, count down to expiry
        t1.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        t1.push_back(mk(0, 1, 5, 0, 0, 5, 0, 0));
        t1.push_back(mk(0, 0, 0, 1, 0, 4, 1, 0));
        t1.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0));
        t1.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0));
        t1.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        t1.push_back(mk(0, 0, 0, 0, 0, 5, 1, 1));
        t1.push_back(mk(0, 0, 0, 0, 0, 4, 1, 0));
        t1.push_back(mk(0, 1, 3, 0, 0, 3, 0, 0));
        t1.push_back(mk(0, 0, 0, 1, 0, 2, 1, 0));
        t1.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
        t1.push_back(mk(0, 0, 0, 0, 0, 3, 1, 1));
        t1.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0));
        t1.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0));
`else
        t1.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
        t1.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        t1.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
`endif
        // boundaries: start with count 0, start&stop together
        t1.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
        t1.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
        t1.push_back(mk(0, 1, 9, 0, 0, 9, 0, 0));
        t1.push_back(mk(0, 0, 0, 1, 1, 9, 0, 0));
        t1.push_back(mk(0, 0, 0, 0, 0, 9, 0, 0));
        // pause at 7 for 4 cycles, then resume
        t1.push_back(mk(0, 1, 10, 0, 0, 10, 0, 0));
        t1.push_back(mk(0, 0, 0, 1, 0, 9, 1, 0));
        t1.push_back(mk(0, 0, 0, 0, 0, 8, 1, 0));
        t1.push_back(mk(0, 0, 0, 0, 0, 7, 1, 0));
        t1.push_back(mk(0, 0, 0, 0, 1, 7, 0, 0));
        t1.push_back(mk(0, 0, 0, 0, 0, 7, 0, 0));
        t1.push_back(mk(0, 0, 0, 0, 0, 7, 0, 0));
        t1.push_back(mk(0, 0, 0, 0, 0, 7, 0, 0));
        t1.push_back(mk(0, 0, 0, 1, 0, 6, 1, 0));
        // load while running stops; reset mid-run at 3
        t1.push_back(mk(0, 1, 4, 0, 0, 4, 0, 0));
        t1.push_back(mk(0, 0, 0, 1, 0, 3, 1, 0));
        t1.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        t1.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
        // load beats start
        t1.push_back(mk(0, 1, 6, 1, 0, 6, 0, 0));
        t1.push_back(mk(0, 0, 0, 0, 1, 6, 0, 0));
        // PRESCALE=3: load 2, start held
        t3.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        t3.push_back(mk(0, 1, 2, 0, 0, 2, 0, 0));
        t3.push_back(mk(0, 0, 0, 1, 0, 2, 1, 0));
        t3.push_back(mk(0, 0, 0, 1, 0, 2, 1, 0));
        t3.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0));
        t3.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0));
        t3.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0));
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        t3.push_back(mk(0, 0, 0, 1, 0, 2, 1, 1));
        t3.push_back(mk(0, 0, 0, 1, 0, 2, 1, 0));
`else
        t3.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
        t3.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
`endif
        // pause keeps prescaler phase: one cycle in, stop, resume needs two more
        t3.push_back(mk(0, 1, 4, 0, 0, 4, 0, 0));
        t3.push_back(mk(0, 0, 0, 1, 0, 4, 1, 0));
        t3.push_back(mk(0, 0, 0, 0, 1, 4, 0, 0));
        t3.push_back(mk(0, 0, 0, 0, 0, 4, 0, 0));
        t3.push_back(mk(0, 0, 0, 1, 0, 4, 1, 0));
        t3.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0));
        t3.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0));
        t3.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        t3.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        foreach (t1[i]) step(1'b0, i, t1[i]);
        foreach (t3[i]) step(1'b1, i, t3[i]);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
